// File: rtl/serial_fifo_pkg.sv
// Shared types and width helpers for the serial receive path.
package serial_fifo_pkg;

   typedef enum logic [0:0] {
      COLLECT  = 1'b0,
      WAIT_ACK = 1'b1
   } des_state_t;

   // Occupancy must represent 0..DEPTH inclusive.
   function automatic int sfl_len_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/serial_fifo_link_if.sv
// Receive-path port bundle: serial bit input, queue controls and queue status.
interface serial_fifo_link_if
   import serial_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int LEN_W = sfl_len_w(DEPTH);

   logic             data_in;
   logic             write_in;
   logic             status_out;
   logic             data_ready;
   logic             enqueue_in;
   logic             dequeue_in;
   logic [WIDTH-1:0] data_out;
   logic [LEN_W-1:0] len_out;
   logic             overflow_out;
   logic             parity_err_out;

   modport master (
      output data_in, write_in, enqueue_in, dequeue_in,
      input  status_out, data_ready, data_out, len_out, overflow_out, parity_err_out
   );

   modport slave (
      input  data_in, write_in, enqueue_in, dequeue_in,
      output status_out, data_ready, data_out, len_out, overflow_out, parity_err_out
   );
endinterface

// File: rtl/sfl_tick_gen.sv
// Clock-enable generator: tick high for one cycle out of every DIV, first tick DIV cycles after reset.
// No backpressure; free-running while out of reset.
module sfl_tick_gen #(
   parameter int DIV = 2
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TOP = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else if (cnt_q == TOP)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + CW'(1);
   end

   assign tick = (cnt_q == TOP);
endmodule

// File: rtl/serial_fifo_link.sv
// MSB-first deserializer into a DEPTH-entry FIFO; word ready 0 cycles after last bit, pop visible on the tick edge.
// Full FIFO holds the word in WAIT_ACK (sticky overflow); optional even parity via SERIAL_FIFO_PARITY_EN.
module serial_fifo_link
   import serial_fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int DES_DIV  = 2,
   parameter int FIFO_DIV = 20
) (
   input  logic              clock,
   input  logic              reset,
   serial_fifo_link_if.slave bus
);
   localparam int LEN_W = sfl_len_w(DEPTH);
   localparam int PTR_W = $clog2(DEPTH);
`ifdef SERIAL_FIFO_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CNT_W = $clog2(NBITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

   logic des_tick;
   logic fifo_tick;

   sfl_tick_gen #(.DIV(DES_DIV)) u_des_tick (
      .clock (clock),
      .reset (reset),
      .tick  (des_tick)
   );

   sfl_tick_gen #(.DIV(FIFO_DIV)) u_fifo_tick (
      .clock (clock),
      .reset (reset),
      .tick  (fifo_tick)
   );

   des_state_t       state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ack_q;
   logic [WIDTH-1:0] shifted;

   assign shifted = {sreg_q[WIDTH-2:0], bus.data_in};

`ifdef SERIAL_FIFO_PARITY_EN
   logic perr_q, perr_d;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= COLLECT;
         sreg_q  <= '0;
         cnt_q   <= '0;
`ifdef SERIAL_FIFO_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_FIFO_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_FIFO_PARITY_EN
      perr_d  = 1'b0;
`endif
      case (state_q)
         COLLECT: begin
            if (des_tick && bus.write_in) begin
               if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_FIFO_PARITY_EN
                  // Final bit is the even-parity bit over the already-shifted word.
                  if (^{sreg_q, bus.data_in}) begin
                     perr_d = 1'b1;
                     cnt_d  = '0;
                  end else begin
                     state_d = WAIT_ACK;
                     cnt_d   = cnt_q + CNT_W'(1);
                  end
`else
                  sreg_d  = shifted;
                  state_d = WAIT_ACK;
                  cnt_d   = cnt_q + CNT_W'(1);
`endif
               end else begin
                  sreg_d = shifted;
                  cnt_d  = cnt_q + CNT_W'(1);
               end
            end
         end
         WAIT_ACK: begin
            if (ack_q) begin
               state_d = COLLECT;
               cnt_d   = '0;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LEN_W-1:0] len_q;
   logic [WIDTH-1:0] dout_q;
   logic             ovf_q;
   logic             full, empty, offer, do_pop, do_push;

   assign full    = (len_q == LEN_W'(DEPTH));
   assign empty   = (len_q == '0);
   // ack_q masks the extra cycle that data_ready stays high after a push.
   assign offer   = fifo_tick && bus.enqueue_in && (state_q == WAIT_ACK) && !ack_q;
   assign do_pop  = fifo_tick && bus.dequeue_in && !empty;
   assign do_push = offer && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (do_push)
         mem[wr_ptr_q] <= sreg_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         len_q    <= '0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         ack_q <= do_push;
         if (do_push)
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            dout_q   <= mem[rd_ptr_q];
         end
         if (offer && full && !do_pop)
            ovf_q <= 1'b1;
         case ({do_push, do_pop})
            2'b10:   len_q <= len_q + LEN_W'(1);
            2'b01:   len_q <= len_q - LEN_W'(1);
            default: len_q <= len_q;
         endcase
      end
   end

   assign bus.status_out   = (state_q == COLLECT);
   assign bus.data_ready   = (state_q == WAIT_ACK);
   assign bus.data_out     = dout_q;
   assign bus.len_out      = len_q;
   assign bus.overflow_out = ovf_q;
`ifdef SERIAL_FIFO_PARITY_EN
   assign bus.parity_err_out = perr_q;
`else
   assign bus.parity_err_out = 1'b0;
`endif
endmodule

// File: tb/tb_serial_fifo_link.sv
// Randomized and directed bench for serial_fifo_link against a queue-based reference model.
module tb_serial_fifo_link;
   localparam int WIDTH    = 8;
   localparam int DEPTH    = 4;
   localparam int DES_DIV  = 2;
   localparam int FIFO_DIV = 4;
`ifdef SERIAL_FIFO_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif

   logic clock = 1'b0;
   logic reset = 1'b0;

   serial_fifo_link_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   serial_fifo_link #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .DES_DIV(DES_DIV), .FIFO_DIV(FIFO_DIV)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;
   int perr_cnt = 0;

   // Reference model state: the edge index since reset release decides tick timing.
   int               edge_cnt;
   bit               last_des, last_fifo;
   int               m_bits;
   logic [WIDTH-1:0] m_word;
   bit               m_ready, m_ack, m_ovf, m_perr;
   logic [WIDTH-1:0] m_dout;
   logic [WIDTH-1:0] m_q [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      edge_cnt  = 0;
      last_des  = 0;
      last_fifo = 0;
      m_bits    = 0;
      m_word    = '0;
      m_ready   = 0;
      m_ack     = 0;
      m_ovf     = 0;
      m_perr    = 0;
      m_dout    = '0;
      m_q.delete();
   endtask

   task automatic model_edge();
      bit pop, push, full_old, new_ack;
      edge_cnt++;
      last_des  = (edge_cnt % DES_DIV) == 0;
      last_fifo = (edge_cnt % FIFO_DIV) == 0;
      new_ack   = 0;
      m_perr    = 0;
      if (last_fifo) begin
         full_old = (m_q.size() == DEPTH);
         pop  = bus.dequeue_in && (m_q.size() > 0);
         push = bus.enqueue_in && m_ready && !m_ack && (!full_old || pop);
         if (bus.enqueue_in && m_ready && !m_ack && full_old && !pop)
            m_ovf = 1;
         if (pop)
            m_dout = m_q.pop_front();
         if (push) begin
            m_q.push_back(m_word);
            new_ack = 1;
         end
      end
      if (m_ready) begin
         if (m_ack) begin
            m_ready = 0;
            m_bits  = 0;
         end
      end else if (last_des && bus.write_in) begin
         if (m_bits < WIDTH)
            m_word = {m_word[WIDTH-2:0], bus.data_in};
         m_bits++;
         if (m_bits == NB) begin
`ifdef SERIAL_FIFO_PARITY_EN
            if ((^m_word) != bus.data_in) begin
               m_perr = 1;
               m_bits = 0;
            end else
               m_ready = 1;
`else
            m_ready = 1;
`endif
         end
      end
      m_ack = new_ack;
   endtask

   task automatic check_outputs();
      check_val("status_out", bus.status_out, !m_ready);
      check_val("data_ready", bus.data_ready, m_ready);
      check_val("data_out", bus.data_out, m_dout);
      check_val("len_out", bus.len_out, m_q.size());
      check_val("overflow_out", bus.overflow_out, m_ovf);
      check_val("parity_err_out", bus.parity_err_out, m_perr);
   endtask

   task automatic step();
      @(posedge clock);
      if (!reset) model_reset();
      else        model_edge();
      @(negedge clock);
      if (bus.parity_err_out) perr_cnt++;
      check_outputs();
   endtask

   task automatic wait_des();
      bit seen = 0;
      for (int k = 0; k <= DES_DIV && !seen; k++) begin
         step();
         seen = last_des;
      end
      if (!seen) check_val("des_tick_timeout", 0, 1);
   endtask

   task automatic wait_fifo();
      bit seen = 0;
      for (int k = 0; k <= FIFO_DIV && !seen; k++) begin
         step();
         seen = last_fifo;
      end
      if (!seen) check_val("fifo_tick_timeout", 0, 1);
   endtask

   task automatic send_bit(input logic b, input bit gap);
      if (gap) begin
         bus.write_in = 1'b0;
         bus.data_in  = 1'($urandom);
         wait_des();
      end
      bus.write_in = 1'b1;
      bus.data_in  = b;
      wait_des();
      bus.write_in = 1'b0;
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] w, input logic par, input bit gap);
      for (int i = 0; i < NB; i++)
         send_bit((i < WIDTH) ? w[WIDTH-1-i] : par, gap);
   endtask

   task automatic push_word(input logic [WIDTH-1:0] w, input bit gap);
      bit done = 0;
      send_frame(w, ^w, gap);
      bus.enqueue_in = 1'b1;
      for (int k = 0; k < 4 * FIFO_DIV && !done; k++) begin
         step();
         done = !bus.data_ready;
      end
      bus.enqueue_in = 1'b0;
      if (!done) check_val("push_timeout", bus.data_ready, 0);
   endtask

   task automatic pop_tick();
      bus.dequeue_in = 1'b1;
      wait_fifo();
      bus.dequeue_in = 1'b0;
   endtask

   initial begin
      bus.data_in    = 1'b0;
      bus.write_in   = 1'b0;
      bus.enqueue_in = 1'b0;
      bus.dequeue_in = 1'b0;
      model_reset();
      repeat (3) step();
      reset = 1'b1;

      // Pass-through of 0xA5
      push_word(8'hA5, 0);
      check_val("pass_len1", bus.len_out, 1);
      pop_tick();
      check_val("pass_dout", bus.data_out, 8'hA5);
      check_val("pass_len0", bus.len_out, 0);

      // Unqualified bits interleaved
      push_word(8'h3C, 1);
      pop_tick();
      check_val("gate_dout", bus.data_out, 8'h3C);

      // Fill, then overflow with 0x55 held
      push_word(8'h11, 0);
      push_word(8'h22, 0);
      push_word(8'h33, 0);
      push_word(8'h44, 0);
      check_val("full_len", bus.len_out, 4);
      send_frame(8'h55, 1'b0, 0);
      bus.enqueue_in = 1'b1;
      repeat (3) wait_fifo();
      check_val("ovf_flag", bus.overflow_out, 1);
      check_val("ovf_ready_held", bus.data_ready, 1);
      check_val("ovf_len", bus.len_out, 4);
      bus.enqueue_in = 1'b0;
      pop_tick();
      check_val("ovf_pop_dout", bus.data_out, 8'h11);
      check_val("ovf_pop_len", bus.len_out, 3);
      bus.enqueue_in = 1'b1;
      wait_fifo();
      check_val("ovf_late_push_len", bus.len_out, 4);
      step();
      bus.enqueue_in = 1'b0;
      check_val("ovf_ack_ready", bus.data_ready, 0);
      pop_tick(); check_val("drain_22", bus.data_out, 8'h22);
      pop_tick(); check_val("drain_33", bus.data_out, 8'h33);
      pop_tick(); check_val("drain_44", bus.data_out, 8'h44);
      pop_tick(); check_val("drain_55", bus.data_out, 8'h55);

      // Simultaneous push and pop at len=2, then pop on empty
      push_word(8'h66, 0);
      push_word(8'h77, 0);
      send_frame(8'h88, 1'b0, 0);
      bus.enqueue_in = 1'b1;
      bus.dequeue_in = 1'b1;
      wait_fifo();
      bus.dequeue_in = 1'b0;
      check_val("simul_len", bus.len_out, 2);
      check_val("simul_dout", bus.data_out, 8'h66);
      step();
      bus.enqueue_in = 1'b0;
      pop_tick(); check_val("simul_77", bus.data_out, 8'h77);
      pop_tick(); check_val("simul_88", bus.data_out, 8'h88);
      pop_tick();
      check_val("empty_pop_dout", bus.data_out, 8'h88);
      check_val("empty_pop_len", bus.len_out, 0);

      // Asynchronous reset in the middle of a word
      push_word(8'h99, 0);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
      reset = 1'b0;
      #1;
      check_val("rst_status", bus.status_out, 1);
      check_val("rst_ready", bus.data_ready, 0);
      check_val("rst_dout", bus.data_out, 0);
      check_val("rst_len", bus.len_out, 0);
      check_val("rst_ovf", bus.overflow_out, 0);
      check_val("rst_perr", bus.parity_err_out, 0);
      repeat (2) step();
      reset = 1'b1;
      push_word(8'hC3, 0);
      pop_tick();
      check_val("post_rst_dout", bus.data_out, 8'hC3);

`ifdef SERIAL_FIFO_PARITY_EN
      perr_cnt = 0;
      send_frame(8'hA5, 1'b1, 0);
      repeat (2) step();
      check_val("perr_pulses", perr_cnt, 1);
      check_val("perr_len", bus.len_out, 0);
      check_val("perr_ready", bus.data_ready, 0);
      push_word(8'hA5, 0);
      pop_tick();
      check_val("par_ok_dout", bus.data_out, 8'hA5);
`endif

      // Random traffic; the model checks every cycle
      for (int c = 0; c < 3000; c++) begin
         bus.write_in   = 1'($urandom_range(0, 1));
         bus.data_in    = 1'($urandom);
         bus.enqueue_in = ($urandom_range(0, 3) != 0);
         bus.dequeue_in = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
